// File: rtl/pipeline_hazard_ctl_if.sv
// Decode-side hazard control bundle: decoded-instruction descriptor,
// branch/memory status in, and pass/PC-advance/scoreboard status out.
interface pipeline_hazard_ctl_if #(
  parameter int NREG = 32
);
  logic            dec_valid;
  logic [4:0]      dec_src1;
  logic            dec_src1_en;
  logic [4:0]      dec_src2;
  logic            dec_src2_en;
  logic [4:0]      dec_dst1;
  logic [4:0]      dec_dst2;
  logic            dec_dst1_en;
  logic            dec_dst2_en;
  logic            dec_rd_flags;
  logic            dec_wr_flags;
  logic            br_taken;
  logic            mem_busy;
  logic            d_pass;
  logic            d_pcincr;
  logic [NREG-1:0] sb_pending;
  logic [15:0]     stall_cycles;

  // Decoder / pipeline side: presents instructions and status.
  modport master (
    output dec_valid, dec_src1, dec_src1_en, dec_src2, dec_src2_en,
           dec_dst1, dec_dst2, dec_dst1_en, dec_dst2_en,
           dec_rd_flags, dec_wr_flags, br_taken, mem_busy,
    input  d_pass, d_pcincr, sb_pending, stall_cycles
  );

  // Hazard controller side.
  modport slave (
    input  dec_valid, dec_src1, dec_src1_en, dec_src2, dec_src2_en,
           dec_dst1, dec_dst2, dec_dst1_en, dec_dst2_en,
           dec_rd_flags, dec_wr_flags, br_taken, mem_busy,
    output d_pass, d_pcincr, sb_pending, stall_cycles
  );
endinterface

// File: rtl/pipeline_hazard_ctl.sv
// Decode-stage hazard controller. A countdown scoreboard tracks in-flight
// GPR and flag writes; dependent instructions are held (NOP injected, PC
// held) until the producer's write is visible. Taken branches insert a
// fixed run of bubbles, a busy memory port stalls fetch, and a saturating
// counter records cycles in which a valid instruction was held back.
module pipeline_hazard_ctl #(
  parameter int WB_LAT    = 3,   // 1..15
  parameter int FLUSH_LEN = 2,   // 1..15
  parameter int NREG      = 32   // index width is fixed at 5 bits
) (
  input  logic                   clk,
  input  logic                   rst,
  pipeline_hazard_ctl_if.slave   bus
);

  localparam logic [3:0] LAT_LOAD   = 4'(WB_LAT);
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_LEN - 1);

  typedef enum logic [1:0] {
    MODE_RUN,
    MODE_HAZARD,
    MODE_MEMSTALL,
    MODE_FLUSH
  } mode_e;

  logic [3:0]      cnt     [NREG];
  logic [3:0]      cnt_nxt [NREG];
  logic [3:0]      fcnt;
  logic [3:0]      flush_cnt;
  logic [15:0]     stall_q;
  logic [NREG-1:0] pending_q;
  logic            hazard;
  logic            issue;
  logic            pass;
  logic            pcincr;
  mode_e           mode;

  // Dependency check of the presented instruction against unfinished writes.
  always_comb begin
    hazard = 1'b0;
    if (bus.dec_valid) begin
      if (bus.dec_src1_en && cnt[bus.dec_src1] != 4'd0) hazard = 1'b1;
      if (bus.dec_src2_en && cnt[bus.dec_src2] != 4'd0) hazard = 1'b1;
      if ((bus.dec_rd_flags || bus.dec_wr_flags) && fcnt != 4'd0) hazard = 1'b1;
    end
  end

  // Prioritised mode select and the resulting pass / PC-advance controls.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    mode   = MODE_RUN;
    pass   = 1'b0;
    pcincr = 1'b0;
    if (flush_cnt != 4'd0 || bus.br_taken) mode = MODE_FLUSH;
    else if (bus.mem_busy)                 mode = MODE_MEMSTALL;
    else if (hazard)                       mode = MODE_HAZARD;
    if (!rst) begin
      case (mode)
        MODE_FLUSH:    pcincr = 1'b1;
        MODE_MEMSTALL,
        MODE_HAZARD:   ;
        default: begin
          pass   = 1'b1;
          pcincr = bus.dec_valid;
        end
      endcase
    end
  end

  assign issue = bus.dec_valid && pass;

  // Next scoreboard value per register: a new write wins over the countdown.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      cnt_nxt[i] = cnt[i];
      if (issue && ((bus.dec_dst1_en && bus.dec_dst1 == 5'(i)) ||
                    (bus.dec_dst2_en && bus.dec_dst2 == 5'(i))))
        cnt_nxt[i] = LAT_LOAD;
      else if (cnt[i] != 4'd0)
        cnt_nxt[i] = cnt[i] - 4'd1;
    end
  end

  // Scoreboard, flag/flush countdowns and stall statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the scoreboard is a small flop array, not a RAM, so it is
      // cleared on reset like any other state; pending writes are dropped.
      for (int i = 0; i < NREG; i++) cnt[i] <= 4'd0;
      fcnt      <= 4'd0;
      flush_cnt <= 4'd0;
      stall_q   <= 16'd0;
      pending_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register here samples the pre-edge values of its inputs.
      for (int i = 0; i < NREG; i++) begin
        cnt[i]       <= cnt_nxt[i];
        pending_q[i] <= (cnt_nxt[i] != 4'd0);
      end

      if (issue && bus.dec_wr_flags) fcnt <= LAT_LOAD;
      else if (fcnt != 4'd0)         fcnt <= fcnt - 4'd1;

      if (bus.br_taken)            flush_cnt <= FLUSH_LOAD;
      else if (flush_cnt != 4'd0)  flush_cnt <= flush_cnt - 4'd1;

      if (bus.dec_valid && !pass && stall_q != 16'hFFFF)
        stall_q <= stall_q + 16'd1;
    end
  end

  assign bus.d_pass       = pass;
  assign bus.d_pcincr     = pcincr;
  assign bus.sb_pending   = pending_q;
  assign bus.stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctl.sv
// Bench for pipeline_hazard_ctl: directed scenarios plus randomized traffic
// checked against a timestamp-based reference model (each write records the
// cycle at which it becomes visible; flushes record the cycle they end).
module tb_pipeline_hazard_ctl;
  localparam int WB_LAT    = 3;
  localparam int FLUSH_LEN = 2;
  localparam int NREG      = 32;

  logic clk = 1'b0;
  logic rst;

  pipeline_hazard_ctl_if #(.NREG(NREG)) bus ();

  pipeline_hazard_ctl #(
    .WB_LAT(WB_LAT), .FLUSH_LEN(FLUSH_LEN), .NREG(NREG)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state: absolute cycle numbers.
  int cyc = 0;
  int ready_at [NREG];
  int flags_ready_at = 0;
  int flush_until = 0;
  int stall_exp = 0;

  function automatic void model_out(output logic p, output logic pc);
    logic haz;
    haz = bus.dec_valid &&
          ((bus.dec_src1_en && ready_at[bus.dec_src1] > cyc) ||
           (bus.dec_src2_en && ready_at[bus.dec_src2] > cyc) ||
           ((bus.dec_rd_flags || bus.dec_wr_flags) && flags_ready_at > cyc));
    if (rst) begin
      p = 1'b0; pc = 1'b0;
    end else if (bus.br_taken || cyc < flush_until) begin
      p = 1'b0; pc = 1'b1;
    end else if (bus.mem_busy || haz) begin
      p = 1'b0; pc = 1'b0;
    end else begin
      p = 1'b1; pc = bus.dec_valid;
    end
  endfunction

  function automatic logic [NREG-1:0] model_pending();
    logic [NREG-1:0] v;
    for (int r = 0; r < NREG; r++) v[r] = (ready_at[r] > cyc);
    return v;
  endfunction

  // Advance one clock; the model consumes the same inputs the DUT sampled.
  task automatic tick();
    logic p, pc;
    model_out(p, pc);
    @(posedge clk);
    if (rst) begin
      for (int r = 0; r < NREG; r++) ready_at[r] = 0;
      flags_ready_at = 0;
      flush_until    = 0;
      stall_exp      = 0;
    end else begin
      if (bus.br_taken) flush_until = cyc + FLUSH_LEN;
      if (bus.dec_valid && p) begin
        if (bus.dec_dst1_en)  ready_at[bus.dec_dst1] = cyc + 1 + WB_LAT;
        if (bus.dec_dst2_en)  ready_at[bus.dec_dst2] = cyc + 1 + WB_LAT;
        if (bus.dec_wr_flags) flags_ready_at = cyc + 1 + WB_LAT;
      end
      if (bus.dec_valid && !p && stall_exp < 65535) stall_exp++;
    end
    cyc++;
    #1;
  endtask

  task automatic idle_inputs();
    bus.dec_valid    = 1'b0;
    bus.dec_src1     = 5'd0;
    bus.dec_src1_en  = 1'b0;
    bus.dec_src2     = 5'd0;
    bus.dec_src2_en  = 1'b0;
    bus.dec_dst1     = 5'd0;
    bus.dec_dst2     = 5'd0;
    bus.dec_dst1_en  = 1'b0;
    bus.dec_dst2_en  = 1'b0;
    bus.dec_rd_flags = 1'b0;
    bus.dec_wr_flags = 1'b0;
    bus.br_taken     = 1'b0;
    bus.mem_busy     = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.dec_valid = 1'b1;   bus.dec_src1 = 5'h1F; bus.dec_src1_en = 1'b1;
    bus.dec_src2  = 5'h1F;  bus.dec_src2_en = 1'b1;
    bus.dec_dst1  = 5'h1F;  bus.dec_dst2 = 5'h1F;
    bus.dec_dst1_en = 1'b1; bus.dec_dst2_en = 1'b1;
    bus.dec_rd_flags = 1'b1; bus.dec_wr_flags = 1'b1;
    bus.br_taken = 1'b1;    bus.mem_busy = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.d_pass !== 1'b0 || bus.d_pcincr !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl got pass=%b pcincr=%b want 0 0", bus.d_pass, bus.d_pcincr);
    end
    checks++;
    if (bus.sb_pending !== '0) begin
      errors++;
      $display("FAIL reset_pending got %h want 0", bus.sb_pending);
    end
    checks++;
    if (bus.stall_cycles !== 16'd0) begin
      errors++;
      $display("FAIL reset_stall got %0d want 0", bus.stall_cycles);
    end
    rst = 1'b0;
    idle_inputs();
    bus.dec_valid = 1'b1;
    #1;
    checks++;
    if (bus.d_pass !== 1'b1 || bus.d_pcincr !== 1'b1) begin
      errors++;
      $display("FAIL reset_release got pass=%b pcincr=%b want 1 1", bus.d_pass, bus.d_pcincr);
    end
    tick();
  endtask

  task automatic test_raw();
    logic exp_pass [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic exp_pend [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    idle_inputs();
    bus.dec_valid = 1'b1; bus.dec_dst1 = 5'd5; bus.dec_dst1_en = 1'b1;
    #1;
    tick();
    idle_inputs();
    bus.dec_valid = 1'b1; bus.dec_src1 = 5'd5; bus.dec_src1_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (bus.d_pass !== exp_pass[k] || bus.d_pcincr !== exp_pass[k]) begin
        errors++;
        $display("FAIL raw_ctl step=%0d got pass=%b pcincr=%b want %b %b",
                 k, bus.d_pass, bus.d_pcincr, exp_pass[k], exp_pass[k]);
      end
      checks++;
      if (bus.sb_pending[5] !== exp_pend[k]) begin
        errors++;
        $display("FAIL raw_pending5 step=%0d got %b want %b", k, bus.sb_pending[5], exp_pend[k]);
      end
      tick();
    end
    checks++;
    if (bus.stall_cycles !== 16'd3) begin
      errors++;
      $display("FAIL raw_stall_count got %0d want 3", bus.stall_cycles);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_dual_flags();
    logic exp_pass [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    idle_inputs();
    bus.dec_valid = 1'b1; bus.dec_dst1 = 5'd2; bus.dec_dst2 = 5'd7;
    bus.dec_dst1_en = 1'b1; bus.dec_dst2_en = 1'b1; bus.dec_wr_flags = 1'b1;
    #1;
    tick();
    checks++;
    if (bus.sb_pending[2] !== 1'b1 || bus.sb_pending[7] !== 1'b1) begin
      errors++;
      $display("FAIL dual_pending got r2=%b r7=%b want 1 1", bus.sb_pending[2], bus.sb_pending[7]);
    end
    idle_inputs();
    bus.dec_valid = 1'b1; bus.dec_rd_flags = 1'b1;
    bus.dec_src1 = 5'd9; bus.dec_src1_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (bus.d_pass !== exp_pass[k] || bus.d_pcincr !== exp_pass[k]) begin
        errors++;
        $display("FAIL flags_ctl step=%0d got pass=%b pcincr=%b want %b %b",
                 k, bus.d_pass, bus.d_pcincr, exp_pass[k], exp_pass[k]);
      end
      tick();
    end
    idle_inputs();
    bus.dec_valid = 1'b1; bus.dec_src1 = 5'd7; bus.dec_src1_en = 1'b1;
    #1;
    checks++;
    if (bus.d_pass !== 1'b1 || bus.d_pcincr !== 1'b1) begin
      errors++;
      $display("FAIL dual_r7_reader got pass=%b pcincr=%b want 1 1", bus.d_pass, bus.d_pcincr);
    end
    tick();
  endtask

  task automatic test_branch();
    // Single branch: two bubbles then run; second scenario reloads mid-flush.
    logic br_seq   [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic exp_pass [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    idle_inputs();
    bus.dec_valid = 1'b1;
    for (int k = 0; k < 7; k++) begin
      bus.br_taken = br_seq[k];
      #1;
      checks++;
      if (bus.d_pass !== exp_pass[k] || bus.d_pcincr !== 1'b1) begin
        errors++;
        $display("FAIL branch step=%0d got pass=%b pcincr=%b want %b 1",
                 k, bus.d_pass, bus.d_pcincr, exp_pass[k]);
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_priority();
    logic exp_pend [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    idle_inputs();
    bus.dec_valid = 1'b1; bus.dec_dst1 = 5'd4; bus.dec_dst1_en = 1'b1;
    #1;
    tick();
    for (int k = 0; k < 4; k++) begin
      idle_inputs();
      bus.dec_valid = (k < 2);
      bus.mem_busy  = (k < 2);
      #1;
      if (k < 2) begin
        checks++;
        if (bus.d_pass !== 1'b0 || bus.d_pcincr !== 1'b0) begin
          errors++;
          $display("FAIL memstall step=%0d got pass=%b pcincr=%b want 0 0",
                   k, bus.d_pass, bus.d_pcincr);
        end
      end
      checks++;
      if (bus.sb_pending[4] !== exp_pend[k]) begin
        errors++;
        $display("FAIL memstall_decrement step=%0d got %b want %b", k, bus.sb_pending[4], exp_pend[k]);
      end
      tick();
    end
    idle_inputs();
    bus.dec_valid = 1'b1; bus.dec_dst1 = 5'd6; bus.dec_dst1_en = 1'b1;
    #1;
    tick();
    idle_inputs();
    bus.dec_valid = 1'b1; bus.dec_src1 = 5'd6; bus.dec_src1_en = 1'b1;
    bus.br_taken = 1'b1; bus.mem_busy = 1'b1;
    #1;
    checks++;
    if (bus.d_pass !== 1'b0 || bus.d_pcincr !== 1'b1) begin
      errors++;
      $display("FAIL priority got pass=%b pcincr=%b want 0 1", bus.d_pass, bus.d_pcincr);
    end
    tick();
    idle_inputs();
    repeat (4) tick();
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    bus.dec_valid = 1'b1; bus.dec_dst1 = 5'd5; bus.dec_dst1_en = 1'b1;
    #1;
    tick();
    idle_inputs();
    bus.br_taken = 1'b1;
    #1;
    tick();
    idle_inputs();
    rst = 1'b1;
    #1;
    tick();
    rst = 1'b0;
    bus.dec_valid = 1'b1; bus.dec_src1 = 5'd5; bus.dec_src1_en = 1'b1;
    #1;
    checks++;
    if (bus.d_pass !== 1'b1 || bus.d_pcincr !== 1'b1 || bus.sb_pending !== '0) begin
      errors++;
      $display("FAIL reset_mid got pass=%b pcincr=%b pending=%h want 1 1 0",
               bus.d_pass, bus.d_pcincr, bus.sb_pending);
    end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_random();
    logic ep, epc;
    for (int n = 0; n < 600; n++) begin
      rst              = ($urandom_range(0, 63) == 0);
      bus.dec_valid    = ($urandom_range(0, 3) != 0);
      bus.dec_src1     = 5'($urandom_range(0, 7));
      bus.dec_src1_en  = 1'($urandom);
      bus.dec_src2     = 5'($urandom_range(0, 7));
      bus.dec_src2_en  = 1'($urandom);
      bus.dec_dst1     = 5'($urandom_range(0, 7));
      bus.dec_dst2     = 5'($urandom_range(0, 7));
      bus.dec_dst1_en  = 1'($urandom);
      bus.dec_dst2_en  = ($urandom_range(0, 3) == 0);
      bus.dec_rd_flags = ($urandom_range(0, 3) == 0);
      bus.dec_wr_flags = ($urandom_range(0, 3) == 0);
      bus.br_taken     = ($urandom_range(0, 7) == 0);
      bus.mem_busy     = ($urandom_range(0, 5) == 0);
      #1;
      model_out(ep, epc);
      checks++;
      if (bus.d_pass !== ep || bus.d_pcincr !== epc) begin
        errors++;
        $display("FAIL rand_ctl cyc=%0d got pass=%b pcincr=%b want %b %b",
                 cyc, bus.d_pass, bus.d_pcincr, ep, epc);
      end
      if (!rst) begin
        checks++;
        if (bus.sb_pending !== model_pending()) begin
          errors++;
          $display("FAIL rand_pending cyc=%0d got %h want %h", cyc, bus.sb_pending, model_pending());
        end
        checks++;
        if (bus.stall_cycles !== 16'(stall_exp)) begin
          errors++;
          $display("FAIL rand_stall cyc=%0d got %0d want %0d", cyc, bus.stall_cycles, stall_exp);
        end
      end
      tick();
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  initial begin
    for (int r = 0; r < NREG; r++) ready_at[r] = 0;
    idle_inputs();
    rst = 1'b1;
    #2;
    test_reset();
    test_raw();
    test_dual_flags();
    test_branch();
    test_priority();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
